// File: rtl/pio_pkg.sv
// Shared definitions for the PIO register initiator: FSM states, address regions,
// and register dword offsets inside the BAR0 region.
package pio_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_WAIT,
      RD_ADDR,
      RD_WAIT,
      RESP
   } state_t;

   localparam logic [1:0] REG_BAR0 = 2'b01;
   localparam logic [1:0] REG_BIOS = 2'b11;

   localparam logic [5:0] IF_V4ADDR  = 6'h00;
   localparam logic [5:0] IF_MAC_HI  = 6'h02;
   localparam logic [5:0] IF_MAC_LO  = 6'h03;
   localparam logic [5:0] DST_V4ADDR = 6'h04;
   localparam logic [5:0] DST_MAC_HI = 6'h06;
   localparam logic [5:0] DST_MAC_LO = 6'h07;

   // The responder's write port is 8 lanes wide; only the low 4 carry dword enables.
   function automatic logic [7:0] wr_be_expand(input logic [3:0] be);
      return {4'h0, be};
   endfunction

endpackage

// File: rtl/pio_reg_initiator_if.sv
// Command/response port of the initiator (agent is master) and the PIO
// memory-access bus toward the register responder (initiator is master).
interface pio_cmd_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [13:0] cmd_addr;
   logic [3:0]  cmd_be;
   logic [31:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

interface pio_mem_if;
   logic [13:0] rd_addr;
   logic [3:0]  rd_be;
   logic [31:0] rd_data;
   logic [13:0] wr_addr;
   logic [7:0]  wr_be;
   logic [31:0] wr_data;
   logic        wr_en;
   logic        wr_busy;

   modport master (
      output rd_addr, rd_be, wr_addr, wr_be, wr_data, wr_en,
      input  rd_data, wr_busy
   );

   modport slave (
      input  rd_addr, rd_be, wr_addr, wr_be, wr_data, wr_en,
      output rd_data, wr_busy
   );
endinterface

// File: rtl/pio_reg_initiator.sv
// Single-outstanding register read/write master on the PIO memory-access bus,
// fed by on-chip agents through a valid/ready command and response port.
module pio_reg_initiator
   import pio_pkg::*;
#(
   parameter int unsigned RD_LAT  = 2,
   parameter int unsigned TMO_CYC = 255,
   parameter int unsigned TMO_W   = 8
) (
   input  logic      clk,
   input  logic      sys_rst_n,
   pio_cmd_if.slave  cmd,
   pio_mem_if.master mem
);

   localparam int unsigned      CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TMO_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

   state_t            state;
   state_t            state_nxt;
   logic [13:0]       addr_q;
   logic [3:0]        be_q;
   logic [31:0]       data_q;
   logic [TMO_W-1:0]  tmo;
   logic [TMO_W-1:0]  tmo_nxt;
   logic [TMO_W-1:0]  tmo_inc;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;

   logic              accept;
   logic              rsp_done;
   logic              wr_timeout;
   logic              rd_done;

   logic              cmd_ready_nxt;
   logic              rsp_valid_nxt;
   logic [31:0]       rsp_data_nxt;
   logic              rsp_err_nxt;
   logic [13:0]       rd_addr_nxt;
   logic [3:0]        rd_be_nxt;
   logic [13:0]       wr_addr_nxt;
   logic [7:0]        wr_be_nxt;
   logic [31:0]       wr_data_nxt;
   logic              wr_en_nxt;

   assign accept     = (state == IDLE) && cmd.cmd_valid && cmd.cmd_ready;
   assign rsp_done   = cmd.rsp_valid && cmd.rsp_ready;
   assign tmo_inc    = (tmo == TMO_MAX) ? tmo : tmo + TMO_W'(1);
   assign wr_timeout = mem.wr_busy && (tmo_inc == TMO_MAX);
   assign rd_done    = (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state         <= IDLE;
         tmo           <= '0;
         cnt           <= '0;
         addr_q        <= '0;
         be_q          <= '0;
         data_q        <= '0;
         cmd.cmd_ready <= 1'b0;
         cmd.rsp_valid <= 1'b0;
         cmd.rsp_data  <= '0;
         cmd.rsp_err   <= 1'b0;
         mem.rd_addr   <= '0;
         mem.rd_be     <= '0;
         mem.wr_addr   <= '0;
         mem.wr_be     <= '0;
         mem.wr_data   <= '0;
         mem.wr_en     <= 1'b0;
      end else begin
         state         <= state_nxt;
         tmo           <= tmo_nxt;
         cnt           <= cnt_nxt;
         if (accept) begin
            addr_q <= cmd.cmd_addr;
            be_q   <= cmd.cmd_be;
            data_q <= cmd.cmd_data;
         end
         cmd.cmd_ready <= cmd_ready_nxt;
         cmd.rsp_valid <= rsp_valid_nxt;
         cmd.rsp_data  <= rsp_data_nxt;
         cmd.rsp_err   <= rsp_err_nxt;
         mem.rd_addr   <= rd_addr_nxt;
         mem.rd_be     <= rd_be_nxt;
         mem.wr_addr   <= wr_addr_nxt;
         mem.wr_be     <= wr_be_nxt;
         mem.wr_data   <= wr_data_nxt;
         mem.wr_en     <= wr_en_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tmo_nxt   = tmo;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            tmo_nxt = '0;
            cnt_nxt = '0;
            if (accept) state_nxt = cmd.cmd_write ? WR_WAIT : RD_ADDR;
         end
         WR_WAIT: begin
            if (!mem.wr_busy || wr_timeout) state_nxt = RESP;
            if (mem.wr_busy)                tmo_nxt   = tmo_inc;
         end
         RD_ADDR: begin
            cnt_nxt   = '0;
            state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            if (rd_done) state_nxt = RESP;
            else         cnt_nxt   = cnt + CNT_W'(1);
         end
         RESP: begin
            if (rsp_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered, so this computes their values for the next cycle.
   // rsp_valid rises one cycle after RESP entry, which puts it right after the wr_en pulse.
   always_comb begin
      cmd_ready_nxt = (state_nxt == IDLE);
      rsp_valid_nxt = (state == RESP) && !rsp_done;
      rsp_data_nxt  = cmd.rsp_data;
      rsp_err_nxt   = cmd.rsp_err;
      rd_addr_nxt   = mem.rd_addr;
      rd_be_nxt     = mem.rd_be;
      wr_addr_nxt   = mem.wr_addr;
      wr_be_nxt     = mem.wr_be;
      wr_data_nxt   = mem.wr_data;
      wr_en_nxt     = 1'b0;
      case (state)
         WR_WAIT: begin
            if (!mem.wr_busy) begin
               wr_en_nxt    = 1'b1;
               wr_addr_nxt  = addr_q;
               wr_be_nxt    = wr_be_expand(be_q);
               wr_data_nxt  = data_q;
               rsp_data_nxt = '0;
               rsp_err_nxt  = 1'b0;
            end else if (wr_timeout) begin
               rsp_data_nxt = '0;
               rsp_err_nxt  = 1'b1;
            end
         end
         RD_ADDR: begin
            rd_addr_nxt = addr_q;
            rd_be_nxt   = be_q;
         end
         RD_WAIT: begin
            if (rd_done) begin
               rsp_data_nxt = mem.rd_data;
               rsp_err_nxt  = 1'b0;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_pio_reg_initiator.sv
// Directed bench for pio_reg_initiator with a registered-read register-file responder.
module tb_pio_reg_initiator;
   import pio_pkg::*;

   localparam int unsigned RD_LAT  = 2;
   localparam int unsigned TMO_CYC = 255;
   localparam logic [13:0] A_MAC_LO = {REG_BAR0, 6'h00, IF_MAC_LO};
   localparam logic [13:0] A_DST_V4 = {REG_BAR0, 6'h00, DST_V4ADDR};
   localparam logic [13:0] A_DST_HI = {REG_BAR0, 6'h00, DST_MAC_HI};

   logic clk       = 1'b0;
   logic sys_rst_n = 1'b1;
   always #5 clk = ~clk;

   pio_cmd_if cmd_bus ();
   pio_mem_if mem_bus ();

   pio_reg_initiator #(.RD_LAT(RD_LAT), .TMO_CYC(TMO_CYC), .TMO_W(8)) dut (
      .clk       (clk),
      .sys_rst_n (sys_rst_n),
      .cmd       (cmd_bus),
      .mem       (mem_bus)
   );

   int checks = 0;
   int errors = 0;

   // Responder: 64-dword register file, read data registered one cycle after rd_addr.
   logic [31:0] regs [0:63];
   bit          model_init = 1'b0;
   always @(posedge clk) begin : responder
      logic [31:0] m;
      if (!model_init) begin
         for (int i = 0; i < 64; i++) regs[i] <= '0;
         regs[3]    <= 32'h789A_005C;  // {mac[15:0]=789A, 8'h00, debug=5C}
         model_init <= 1'b1;
      end else if (mem_bus.wr_en) begin
         m = regs[mem_bus.wr_addr[5:0]];
         for (int b = 0; b < 4; b++)
            if (mem_bus.wr_be[b]) m[31-8*b -: 8] = mem_bus.wr_data[31-8*b -: 8];
         regs[mem_bus.wr_addr[5:0]] <= m;
      end
      mem_bus.rd_data <= regs[mem_bus.rd_addr[5:0]];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int wr_pulses = 0;
   int wr_en_cyc = 0;
   int acc_q[$];
   always @(negedge clk) begin
      if (mem_bus.wr_en === 1'b1) begin
         wr_pulses++;
         wr_en_cyc = cyc;
      end
      if (cmd_bus.cmd_valid === 1'b1 && cmd_bus.cmd_ready === 1'b1) acc_q.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [13:0] a, input logic [3:0] be,
                        input logic [31:0] d, output int acc);
      int n = 0;
      cmd_bus.cmd_write = wr;
      cmd_bus.cmd_addr  = a;
      cmd_bus.cmd_be    = be;
      cmd_bus.cmd_data  = d;
      cmd_bus.cmd_valid = 1'b1;
      while (cmd_bus.cmd_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) chk("cmd_ready_wait", 32'd0, 32'd1);
      tick();
      cmd_bus.cmd_valid = 1'b0;
      acc = cyc;
   endtask

   task automatic wait_rsp(input int acc, output int lat);
      int n = 0;
      while (cmd_bus.rsp_valid !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      if (n >= 400) chk("rsp_valid_wait", 32'd0, 32'd1);
      lat = cyc - acc;
   endtask

   task automatic consume();
      cmd_bus.rsp_ready = 1'b1;
      tick();
      cmd_bus.rsp_ready = 1'b0;
   endtask

   task automatic b2b(input logic wr, input logic [13:0] a, output int p1, output int p2);
      int n = 0;
      acc_q.delete();
      cmd_bus.cmd_write = wr;
      cmd_bus.cmd_addr  = a;
      cmd_bus.cmd_be    = 4'hF;
      cmd_bus.cmd_data  = 32'h0A00_1501;
      cmd_bus.rsp_ready = 1'b1;
      cmd_bus.cmd_valid = 1'b1;
      while (acc_q.size() < 3 && n < 80) begin
         tick();
         n++;
      end
      cmd_bus.cmd_valid = 1'b0;
      if (n >= 80) chk("b2b_accepts", acc_q.size(), 32'd3);
      n = 0;
      while (!(cmd_bus.cmd_ready === 1'b1 && cmd_bus.rsp_valid === 1'b0) && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) chk("b2b_drain", 32'd0, 32'd1);
      cmd_bus.rsp_ready = 1'b0;
      p1 = acc_q.size() > 1 ? acc_q[1] - acc_q[0] : 0;
      p2 = acc_q.size() > 2 ? acc_q[2] - acc_q[1] : 0;
   endtask

   initial begin
      int acc, lat, p1, p2, pulses0, seen;
      logic [31:0] d0;
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_write = 1'b0;
      cmd_bus.cmd_addr  = '0;
      cmd_bus.cmd_be    = '0;
      cmd_bus.cmd_data  = '0;
      cmd_bus.rsp_ready = 1'b0;
      mem_bus.wr_busy   = 1'b0;

      // Reset state
      #2 sys_rst_n = 1'b0;
      #1;
      chk("rst_cmd_ready", cmd_bus.cmd_ready, 32'd0);
      chk("rst_rsp_valid", cmd_bus.rsp_valid, 32'd0);
      chk("rst_wr_en", mem_bus.wr_en, 32'd0);
      chk("rst_rd_addr", mem_bus.rd_addr, 32'd0);
      repeat (3) tick();
      sys_rst_n = 1'b1;
      tick();
      chk("rel_cmd_ready", cmd_bus.cmd_ready, 32'd1);

      // Full-dword write, unstalled
      pulses0 = wr_pulses;
      issue(1'b1, A_DST_V4, 4'hF, 32'h0A00_1501, acc);
      wait_rsp(acc, lat);
      chk("wr_latency", lat, 32'd2);
      chk("wr_pulses", wr_pulses - pulses0, 32'd1);
      chk("wr_addr", mem_bus.wr_addr, 32'h1004);
      chk("wr_be", mem_bus.wr_be, 32'h0F);
      chk("wr_data", mem_bus.wr_data, 32'h0A00_1501);
      chk("wr_rsp_err", cmd_bus.rsp_err, 32'd0);
      chk("wr_rsp_data", cmd_bus.rsp_data, 32'd0);
      consume();
      chk("wr_done_ready", cmd_bus.cmd_ready, 32'd1);
      chk("wr_done_valid", cmd_bus.rsp_valid, 32'd0);

      // Read latency and data path
      issue(1'b0, A_MAC_LO, 4'hF, 32'h0, acc);
      wait_rsp(acc, lat);
      chk("rd_latency", lat, RD_LAT + 2);
      chk("rd_data", cmd_bus.rsp_data, 32'h789A_005C);
      chk("rd_err", cmd_bus.rsp_err, 32'd0);
      chk("rd_addr", mem_bus.rd_addr, 32'h1003);
      chk("rd_be", mem_bus.rd_be, 32'hF);
      consume();

      issue(1'b0, A_DST_V4, 4'hF, 32'h0, acc);
      wait_rsp(acc, lat);
      chk("readback_v4", cmd_bus.rsp_data, 32'h0A00_1501);
      consume();

      // Partial write: be[0] -> [31:24], be[2] -> [15:8]
      issue(1'b1, A_DST_HI, 4'b0101, 32'hAABB_CCDD, acc);
      wait_rsp(acc, lat);
      chk("pw_wr_be", mem_bus.wr_be, 32'h05);
      consume();
      issue(1'b0, A_DST_HI, 4'hF, 32'h0, acc);
      wait_rsp(acc, lat);
      chk("pw_readback", cmd_bus.rsp_data, 32'hAA00_CC00);
      consume();

      // Busy for 10 cycles after WR_WAIT entry
      pulses0 = wr_pulses;
      mem_bus.wr_busy = 1'b1;
      issue(1'b1, A_DST_V4, 4'hF, 32'h1234_5678, acc);
      repeat (10) tick();
      mem_bus.wr_busy = 1'b0;
      wait_rsp(acc, lat);
      chk("stall_wr_en_cyc", wr_en_cyc - acc, 32'd11);
      chk("stall_pulses", wr_pulses - pulses0, 32'd1);
      chk("stall_latency", lat, 32'd12);
      chk("stall_err", cmd_bus.rsp_err, 32'd0);
      consume();

      // Busy rising while wr_en is high still counts as issued
      pulses0 = wr_pulses;
      issue(1'b1, A_DST_V4, 4'hF, 32'h0A00_1501, acc);
      tick();
      mem_bus.wr_busy = 1'b1;
      wait_rsp(acc, lat);
      chk("late_busy_err", cmd_bus.rsp_err, 32'd0);
      chk("late_busy_pulses", wr_pulses - pulses0, 32'd1);
      consume();

      // Timeout: busy stuck high
      pulses0 = wr_pulses;
      issue(1'b1, A_DST_V4, 4'hF, 32'hDEAD_BEEF, acc);
      wait_rsp(acc, lat);
      chk("tmo_latency", lat, TMO_CYC + 1);
      chk("tmo_err", cmd_bus.rsp_err, 32'd1);
      chk("tmo_data", cmd_bus.rsp_data, 32'd0);
      chk("tmo_no_wr_en", wr_pulses - pulses0, 32'd0);
      consume();
      mem_bus.wr_busy = 1'b0;
      issue(1'b0, A_DST_V4, 4'hF, 32'h0, acc);
      wait_rsp(acc, lat);
      chk("post_tmo_latency", lat, RD_LAT + 2);
      chk("post_tmo_data", cmd_bus.rsp_data, 32'h0A00_1501);
      chk("post_tmo_err", cmd_bus.rsp_err, 32'd0);
      consume();

      // Back-to-back: accept-to-handshake latency + 1 re-arm cycle
      b2b(1'b0, A_MAC_LO, p1, p2);
      chk("b2b_rd_p1", p1, RD_LAT + 4);
      chk("b2b_rd_p2", p2, RD_LAT + 4);
      b2b(1'b1, A_DST_V4, p1, p2);
      chk("b2b_wr_p1", p1, 32'd4);
      chk("b2b_wr_p2", p2, 32'd4);

      // Backpressure: response held, new command ignored
      issue(1'b0, A_MAC_LO, 4'hF, 32'h0, acc);
      wait_rsp(acc, lat);
      d0 = cmd_bus.rsp_data;
      chk("bp_data0", d0, 32'h789A_005C);
      cmd_bus.cmd_addr  = A_DST_V4;
      cmd_bus.cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", cmd_bus.rsp_valid, 32'd1);
         chk("bp_data", cmd_bus.rsp_data, 32'h789A_005C);
         chk("bp_cmd_ready", cmd_bus.cmd_ready, 32'd0);
      end
      cmd_bus.cmd_valid = 1'b0;
      consume();

      // Reset asserted while in RD_WAIT
      issue(1'b0, A_MAC_LO, 4'hF, 32'h0, acc);
      tick();
      #2 sys_rst_n = 1'b0;
      #1;
      chk("mr_rd_addr", mem_bus.rd_addr, 32'd0);
      chk("mr_rd_be", mem_bus.rd_be, 32'd0);
      chk("mr_rsp_data", cmd_bus.rsp_data, 32'd0);
      chk("mr_cmd_ready", cmd_bus.cmd_ready, 32'd0);
      chk("mr_rsp_valid", cmd_bus.rsp_valid, 32'd0);
      chk("mr_wr_addr", mem_bus.wr_addr, 32'd0);
      chk("mr_wr_data", mem_bus.wr_data, 32'd0);
      chk("mr_wr_be", mem_bus.wr_be, 32'd0);
      repeat (2) tick();
      sys_rst_n = 1'b1;
      tick();
      chk("mr_rel_ready", cmd_bus.cmd_ready, 32'd1);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (cmd_bus.rsp_valid !== 1'b0) seen++;
      end
      chk("mr_no_stale_rsp", seen, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
